// File: rtl/seq_num_allocator.sv
// Circular sequence-number allocator: grants tail, retires head, optional squash.
// Squash support is built only when SEQ_NUM_ALLOCATOR_SQUASH_EN is defined.
module seq_num_allocator #(
    parameter int p_seq_num_bits = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_val,
    output logic                      alloc_rdy,
    output logic [p_seq_num_bits-1:0] alloc_seq_num,
    input  logic                      commit_val,
    input  logic [p_seq_num_bits-1:0] commit_seq_num,
    input  logic                      squash_val,
    input  logic [p_seq_num_bits-1:0] squash_seq_num,
    output logic [p_seq_num_bits:0]   count,
    output logic                      full,
    output logic                      empty,
    output logic                      err
);

    localparam int W = p_seq_num_bits;
    localparam logic [W:0] D = (W+1)'(2**W);

`ifdef SEQ_NUM_ALLOCATOR_SQUASH_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [W:0]   count_r;
    logic         err_r;

    logic [W-1:0] head_n;
    logic [W-1:0] tail_n;
    logic [W:0]   count_n;
    logic         err_n;

    logic [W-1:0] sq_off;
    logic         sq_in_range;
    logic         squash_fire;
    logic         squash_bad;
    logic         commit_ok;
    logic         commit_bad;
    logic         alloc_fire;

    assign count = count_r;
    assign err   = err_r;
    assign full  = (count_r == D);
    assign empty = (count_r == '0);

    // Offset of the squash target from head, modulo D.
    assign sq_off      = squash_seq_num - head;
    assign sq_in_range = ({1'b0, sq_off} < count_r);
    assign squash_fire = SQ_EN && squash_val && sq_in_range;
    assign squash_bad  = SQ_EN && squash_val && !sq_in_range;

    assign commit_ok  = commit_val && !empty && (commit_seq_num == head);
    assign commit_bad = commit_val && !commit_ok;

    assign alloc_seq_num = tail;
    assign alloc_rdy     = !full && !squash_fire;
    assign alloc_fire    = alloc_val && alloc_rdy;

    always_comb begin
        head_n  = head;
        tail_n  = tail;
        count_n = count_r;
        err_n   = err_r || commit_bad || squash_bad;
        if (commit_ok) begin
            head_n = head + 1'b1;
        end
        if (squash_fire) begin
            // Survivors run head..squash_seq_num; a same-cycle commit drops head.
            tail_n = squash_seq_num + 1'b1;
            if (commit_ok) begin
                count_n = {1'b0, sq_off};
            end else begin
                count_n = {1'b0, sq_off} + 1'b1;
            end
        end else begin
            if (alloc_fire) begin
                tail_n = tail + 1'b1;
            end
            unique case ({alloc_fire, commit_ok})
                2'b10:   count_n = count_r + 1'b1;
                2'b01:   count_n = count_r - 1'b1;
                default: count_n = count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            head    <= head_n;
            tail    <= tail_n;
            count_r <= count_n;
            err_r   <= err_n;
        end
    end

endmodule

// File: tb/tb_seq_num_allocator.sv
// Scoreboard bench for seq_num_allocator (D = 4) against a queue-based model.
// Grants are predicted on issue and checked by an independent monitor.
module tb_seq_num_allocator;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_val;
    logic         alloc_rdy;
    logic [W-1:0] alloc_seq_num;
    logic         commit_val;
    logic [W-1:0] commit_seq_num;
    logic         squash_val;
    logic [W-1:0] squash_seq_num;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         err;

    seq_num_allocator #(.p_seq_num_bits(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_val      (alloc_val),
        .alloc_rdy      (alloc_rdy),
        .alloc_seq_num  (alloc_seq_num),
        .commit_val     (commit_val),
        .commit_seq_num (commit_seq_num),
        .squash_val     (squash_val),
        .squash_seq_num (squash_seq_num),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .err            (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: the in-flight numbers oldest first, plus the next number to hand out.
    int infl[$];
    int nxt   = 0;
    bit err_m = 1'b0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit in_flight(input int n);
        foreach (infl[i]) if (infl[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every real grant must match the oldest predicted grant.
    always @(negedge clk) begin
        if (!rst && alloc_val && alloc_rdy) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", int'(alloc_seq_num), -1);
            end else begin
                check("grant_num", int'(alloc_seq_num), exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit r, input bit a, input bit c, input int cs,
                        input bit s, input int ss);
        bit cm_ok;
        bit sq_ok;
        bit sq_bad;
        bit grant;
        rst            = r;
        alloc_val      = a;
        commit_val     = c;
        commit_seq_num = W'(cs);
        squash_val     = s;
        squash_seq_num = W'(ss);
        cm_ok = c && infl.size() > 0 && infl[0] == cs;
`ifdef SEQ_NUM_ALLOCATOR_SQUASH_EN
        sq_ok  = s && in_flight(ss);
        sq_bad = s && !in_flight(ss);
`else
        sq_ok  = 1'b0;
        sq_bad = 1'b0;
`endif
        grant = a && infl.size() < D && !sq_ok;
        if (!r && grant) exp_q.push_back(nxt);
        #1;
        if (!r) check("alloc_rdy", int'(alloc_rdy), int'(infl.size() < D && !sq_ok));
        @(posedge clk);
        #1;
        if (r) begin
            infl.delete();
            nxt   = 0;
            err_m = 1'b0;
        end else begin
            if (sq_ok) begin
                while (infl[$] != ss) void'(infl.pop_back());
                nxt = (ss + 1) % D;
            end
            if (cm_ok) void'(infl.pop_front());
            if (grant) begin
                infl.push_back(nxt);
                nxt = (nxt + 1) % D;
            end
            err_m = err_m || (c && !cm_ok) || sq_bad;
        end
        check("count", int'(count), infl.size());
        check("empty", int'(empty), int'(infl.size() == 0));
        check("full", int'(full), int'(infl.size() == D));
        check("err", int'(err), int'(err_m));
        check("next_seq", int'(alloc_seq_num), nxt);
    endtask

    initial begin
        rst = 1'b1; alloc_val = 0; commit_val = 0; squash_val = 0;
        commit_seq_num = '0; squash_seq_num = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        check("reset_alloc_rdy", int'(alloc_rdy), 1);
        // Fill: 0..3 granted, fifth request refused while full.
        repeat (5) step(0, 1, 0, 0, 0, 0);
        check("fill_count", int'(count), 4);
        // Commit 0 while full and requesting: no bypass, then wrap to 0.
        step(0, 1, 1, 0, 0, 0);
        check("wrap_seq", int'(alloc_seq_num), 0);
        check("wrap_count", int'(count), 3);
        // {1,2,3} in flight: out-of-order commit is an error.
        step(0, 0, 1, 2, 0, 0);
        check("bad_commit_err", int'(err), 1);
        step(0, 0, 0, 0, 0, 0);
        check("err_sticky", int'(err), 1);
        // Squash 1 with commit 1.
        step(0, 0, 1, 1, 1, 1);
        // Squash 3 with {0,1} in flight.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3);
        // Reset overrides same-cycle alloc and commit.
        step(1, 1, 1, 0, 0, 0);
        check("rst_count", int'(count), 0);
        check("rst_seq", int'(alloc_seq_num), 0);
        check("rst_err", int'(err), 0);
        for (int i = 0; i < 600; i++) begin
            bit r, a, c, s;
            int cs, ss;
            r  = ($urandom_range(0, 49) == 0);
            a  = ($urandom_range(0, 9) < 6);
            c  = ($urandom_range(0, 9) < 4);
            cs = (infl.size() > 0 && $urandom_range(0, 9) < 9) ?
                 infl[0] : int'($urandom_range(0, D - 1));
            s  = ($urandom_range(0, 9) < 2);
            ss = $urandom_range(0, D - 1);
            step(r, a, c, cs, s, ss);
        end
        step(0, 0, 0, 0, 0, 0);
        check("grants_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_num_allocator.md
SEQ_NUM_ALLOCATOR -- requirements
Module: seq_num_allocator

Interface
REQ-001 SHALL have parameter p_seq_num_bits, default 5; width of sequence numbers; in-flight depth D = 2**p_seq_num_bits.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port alloc_val  input  1  decode requests a new sequence number.
REQ-005 SHALL have port alloc_rdy  output  1  allocator can grant a number this cycle.
REQ-006 SHALL have port alloc_seq_num  output  p_seq_num_bits  number granted when alloc_val && alloc_rdy.
REQ-007 SHALL have port commit_val  input  1  commit notification for the oldest in-flight number.
REQ-008 SHALL have port commit_seq_num  input  p_seq_num_bits  number being committed.
REQ-009 SHALL have port squash_val  input  1  kill all numbers younger than squash_seq_num.
REQ-010 SHALL have port squash_seq_num  input  p_seq_num_bits  youngest surviving number.
REQ-011 SHALL have port count  output  p_seq_num_bits+1  number of in-flight sequence numbers.
REQ-012 SHALL have port full  output  1  count == D.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-015 SHALL hold registers head (oldest in flight), tail (next to allocate) and count; pointer arithmetic is modulo D (natural wrap).
REQ-016 SHALL drive alloc_seq_num = tail combinationally; alloc_rdy = !full && !squash_fire.
REQ-017 SHALL, on alloc fire, advance tail by 1 at next edge; zero-cycle latency from request to granted number.
REQ-018 SHALL accept commit only when !empty and commit_seq_num == head; accepted commit advances head by 1.
REQ-019 SHALL ignore a commit while empty or with commit_seq_num != head, leaving state unchanged, and set err.
REQ-020 SHALL, when full, refuse allocation even if a commit fires the same cycle (no same-cycle bypass).
REQ-021 SHALL, with alloc and commit both firing, keep count unchanged while advancing both head and tail.
REQ-022 SHALL accept squash only if squash_seq_num is in flight, i.e. (squash_seq_num - head) mod D < count; accepted squash sets tail <= squash_seq_num + 1.
REQ-023 SHALL ignore an out-of-range squash, leaving state unchanged, and set err.
REQ-024 SHALL, on simultaneous accepted squash and commit, set count = (squash_seq_num + 1 - (head + 1)) mod D, computed with p_seq_num_bits+1 bits, and set count = 0 when squash_seq_num == head.
REQ-025 SHALL derive full and empty from the registered count only.
REQ-026 SHALL hold err at 1 once set, until reset.

Reset
REQ-027 SHALL, on rst, set head = 0, tail = 0, count = 0 and err = 0, giving empty = 1, full = 0, alloc_rdy = 1 and alloc_seq_num = 0 in the cycle after reset.
REQ-028 SHALL let rst override all same-cycle alloc, commit and squash activity; numbers in flight are discarded.

Configuration
REQ-029 SHALL gate squash support with macro SEQ_NUM_ALLOCATOR_SQUASH_EN.
REQ-030 SHALL, with SEQ_NUM_ALLOCATOR_SQUASH_EN defined, implement REQ-022 to REQ-024.
REQ-031 SHALL, with SEQ_NUM_ALLOCATOR_SQUASH_EN undefined, keep the squash ports but ignore them: squash_fire = 0, squash never sets err, and alloc_rdy = !full.

Verification (p_seq_num_bits = 2, D = 4)
REQ-032 SHALL verify: after reset, alloc_val held for 5 cycles -> numbers 0,1,2,3 granted; in cycle 5 alloc_rdy = 0, full = 1, count = 4.
REQ-033 SHALL verify: when full, commit 0 together with alloc_val -> no grant that cycle; next cycle alloc_seq_num = 0 (wrap), count = 3.
REQ-034 SHALL verify: in flight {1,2,3}, commit 2 -> ignored, err = 1 and stays 1; head remains 1.
REQ-035 SHALL verify: in flight {1,2,3} with squash macro defined, squash 1 plus commit 1 same cycle -> count = 0, empty = 1, next alloc_seq_num = 2.
REQ-036 SHALL verify: squash 3 while {0,1} in flight -> ignored, err = 1; with the macro undefined -> ignored and err stays 0.
REQ-037 SHALL verify: alloc_val, commit and rst asserted in the same cycle -> count = 0, alloc_seq_num = 0, err = 0.
